alu_result_queue: RTL

//  Downstream stage of the combinational ALU. Captures {opcode, result, statusOut} into a

---
 rtl/alu_result_queue.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_result_queue.sv
// rtl/alu_result_queue.sv - result FIFO behind the ALU with sticky status flags
//
// Purpose:
//   Captures {opcode, result, status} from the combinational ALU into a
//   DEPTH-entry FIFO with valid/ready handshakes on both sides, so the
//   writeback consumer can stall. Keeps a sticky OR of the status flags of
//   every accepted entry. Status bit map: [3]=N, [2]=Z, [1]=C, [0]=V.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake (in_ready is combinational)
//   in_opcode/result/status  entry fields captured on push
//   out_valid/out_ready  downstream handshake
//   out_opcode/result/status head entry, driven straight from storage
//   count                occupancy, 0..DEPTH
//   flags_sticky         OR of pushed status since reset or last clear
//   flags_clr            clears flags_sticky (same-cycle pushed bits survive)
//   trap, trap_ack       overflow trap and acknowledge (ALU_RQ_TRAP_EN only)
//
// Configuration:
//   ALU_RQ_TRAP_EN - when defined, a push with V set enters a trap state
//   that blocks further pushes until trap_ack.

module alu_result_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_opcode,
  input  logic [WIDTH-1:0]           in_result,
  input  logic [3:0]                 in_status,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_opcode,
  output logic [WIDTH-1:0]           out_result,
  output logic [3:0]                 out_status,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [3:0]                 flags_sticky,
  input  logic                       flags_clr
`ifdef ALU_RQ_TRAP_EN
  ,
  output logic                       trap,
  input  logic                       trap_ack
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [3:0]       r_opcode [DEPTH];
  logic [WIDTH-1:0] r_result [DEPTH];
  logic [3:0]       r_status [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [3:0]       r_flags;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_trap_hold;

  // Full check ignores out_ready on purpose: a full queue never accepts,
  // even when the head is popped in the same cycle.
  assign w_full    = (r_count == CW'(DEPTH));
  assign in_ready  = !rst && !w_full && !w_trap_hold;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign out_opcode   = r_opcode[r_rd_ptr];
  assign out_result   = r_result[r_rd_ptr];
  assign out_status   = r_status[r_rd_ptr];
  assign count        = r_count;
  assign flags_sticky = r_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_flags  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_opcode[i] <= '0;
        r_result[i] <= '0;
        r_status[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_opcode[r_wr_ptr] <= in_opcode;
        r_result[r_wr_ptr] <= in_result;
        r_status[r_wr_ptr] <= in_status;
        // DEPTH is a power of two, so the pointer wraps by overflow.
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Clear first, then OR in the pushed status so it is never lost.
      r_flags <= (flags_clr ? 4'b0000 : r_flags) | (w_push ? in_status : 4'b0000);
    end
  end

`ifdef ALU_RQ_TRAP_EN
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  state_t r_state;
  logic   r_trap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_trap  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // The overflowing entry itself is still enqueued by w_push.
          if (w_push && in_status[0]) begin
            r_state <= ST_TRAP;
            r_trap  <= 1'b1;
          end
        end
        ST_TRAP: begin
          if (trap_ack) begin
            r_state <= ST_IDLE;
            r_trap  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_trap  <= 1'b0;
        end
      endcase
    end
  end

  assign trap        = r_trap;
  assign w_trap_hold = r_trap;
`else
  assign w_trap_hold = 1'b0;
`endif

endmodule
